// File: rtl/logic_system_pkg.sv
// Shared constants and the AND-OR reference function for the logic_system cell.
package logic_system_pkg;

  localparam int unsigned SYNC_MAX = 3;

  localparam logic OUT_RST   = 1'b0;
  localparam logic OUT_N_RST = 1'b1;

  // Operand bundle in truth-table order {d,c,b,a}
  typedef struct packed {
    logic d;
    logic c;
    logic b;
    logic a;
  } lsys_in_t;

  function automatic logic lsys_f(input logic a, input logic b,
                                  input logic c, input logic d);
    return (a & b) | (c & d);
  endfunction

endpackage

// File: rtl/logic_system_sync_bit.sv
// Single-bit input synchronizer: STAGES-deep async-reset flop chain, or a wire when STAGES is 0.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign q = d;
  end else begin : g_chain
    logic [STAGES-1:0] sh;

    // Shift in at bit 0, oldest sample leaves from the top bit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh <= '0;
      end else begin
        sh <= (sh << 1) | STAGES'(d);
      end
    end

    assign q = sh[STAGES-1];
  end

endmodule

// File: rtl/logic_system.sv
// Registered two-term AND-OR cell with complementary outputs and per-input synchronizers.
module logic_system
  import logic_system_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned REG_OUT     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic out,
  output logic out_n
);

  if (SYNC_STAGES > SYNC_MAX || REG_OUT > 1) begin : g_bad_params
    $error("logic_system: SYNC_STAGES must be 0..3 and REG_OUT 0..1");
  end

  logic as, bs, cs, ds;
  logic f_c;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst_n(rst_n), .d(a), .q(as));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst_n(rst_n), .d(b), .q(bs));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_c (.clk(clk), .rst_n(rst_n), .d(c), .q(cs));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_d (.clk(clk), .rst_n(rst_n), .d(d), .q(ds));

  assign f_c = lsys_f(as, bs, cs, ds);

  // One source drives both outputs so they can never agree
  if (REG_OUT != 0) begin : g_reg
    logic out_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= OUT_RST;
      end else begin
        out_q <= f_c;
      end
    end

    assign out   = out_q;
    assign out_n = ~out_q;
  end else begin : g_comb
    assign out   = f_c;
    assign out_n = ~f_c;
  end

endmodule

// File: tb/tb_logic_system.sv
// Self-checking bench for logic_system: truth-table sweep, reset, latency per configuration, toggling.
module tb_logic_system;
  import logic_system_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c, d;
  logic out, out_n;
  logic lat_out   [8];
  logic lat_out_n [8];

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  logic_system #(.SYNC_STAGES(2), .REG_OUT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .out(out), .out_n(out_n)
  );

  // Index gi encodes SYNC_STAGES = gi/2, REG_OUT = gi%2
  for (genvar gi = 0; gi < 8; gi++) begin : g_cfg
    logic_system #(.SYNC_STAGES(gi / 2), .REG_OUT(gi % 2)) u_cfg (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
      .out(lat_out[gi]), .out_n(lat_out_n[gi])
    );
  end

  typedef struct {
    logic [3:0] idx;
    logic       exp;
  } vec_t;

  vec_t sweep [16];
  vec_t bound [8];

  task automatic chk(input string name, input logic act, input logic exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_pair(input string name, input logic o, input logic on);
    ncmp++;
    if (o === on || $isunknown({o, on})) begin
      nerr++;
      $display("FAIL %s: out=%b out_n=%b, required complementary (t=%0t)", name, o, on, $time);
    end
  endtask

  task automatic set_in(input logic [3:0] v);
    {d, c, b, a} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        prev;
    logic        exp_now;
    logic [3:0]  hist [50];
    int          lat;

    // Hand-computed truth table
    for (int i = 0; i < 16; i++) begin
      sweep[i].idx = 4'(i);
      sweep[i].exp = 1'b0;
    end
    sweep[3].exp  = 1'b1;
    sweep[7].exp  = 1'b1;
    sweep[11].exp = 1'b1;
    sweep[12].exp = 1'b1;
    sweep[13].exp = 1'b1;
    sweep[14].exp = 1'b1;
    sweep[15].exp = 1'b1;

    bound[0] = '{4'd1,  1'b0};
    bound[1] = '{4'd2,  1'b0};
    bound[2] = '{4'd4,  1'b0};
    bound[3] = '{4'd8,  1'b0};
    bound[4] = '{4'd5,  1'b0};
    bound[5] = '{4'd10, 1'b0};
    bound[6] = '{4'd3,  1'b1};
    bound[7] = '{4'd12, 1'b1};

    // Reset state
    rst_n = 1'b0;
    set_in(4'h0);
    repeat (3) tick();
    chk("reset_out", out, OUT_RST);
    chk("reset_out_n", out_n, OUT_N_RST);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_out", out, 1'b0);

    // Exhaustive sweep, 10 cycles per index
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_in(sweep[i].idx);
      for (int j = 1; j <= 10; j++) begin
        tick();
        exp_now = (j >= 3) ? sweep[i].exp : prev;
        chk($sformatf("sweep_idx%0d_cyc%0d", i, j), out, exp_now);
        chk_pair($sformatf("sweep_pair_idx%0d_cyc%0d", i, j), out, out_n);
      end
      prev = sweep[i].exp;
    end

    // Boundary product terms
    for (int i = 0; i < 8; i++) begin
      set_in(bound[i].idx);
      repeat (4) tick();
      chk($sformatf("bound_idx%0d", bound[i].idx), out, bound[i].exp);
      chk($sformatf("bound_n_idx%0d", bound[i].idx), out_n, ~bound[i].exp);
    end

    // Asynchronous reset assertion between edges, then release
    set_in(4'hF);
    repeat (4) tick();
    chk("rst_pre_out", out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", out, 1'b0);
    chk("rst_async_out_n", out_n, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rst_cfg%0d_out", k), lat_out[k], (k == 0) ? 1'b1 : 1'b0);
    end
    tick();
    chk("rst_hold_out", out, 1'b0);
    rst_n = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk($sformatf("rst_release_edge%0d", j), out, (j == 3) ? 1'b1 : 1'b0);
    end

    // Latency per configuration, input 0 -> 3
    set_in(4'h0);
    repeat (5) tick();
    set_in(4'h3);
    #1;
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) tick();
      for (int k = 0; k < 8; k++) begin
        lat = (k / 2) + (k % 2);
        chk($sformatf("lat_cfg%0d_edge%0d", k, n), lat_out[k], (n >= lat) ? 1'b1 : 1'b0);
        chk_pair($sformatf("lat_pair_cfg%0d_edge%0d", k, n), lat_out[k], lat_out_n[k]);
      end
    end

    // Mid-flight reset must discard the partially propagated 12
    set_in(4'h0);
    repeat (5) tick();
    set_in(4'd12);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_assert_out", out, 1'b0);
    tick();
    chk("midrst_hold_out", out, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk($sformatf("midrst_release_edge%0d", j), out, (j == 3) ? 1'b1 : 1'b0);
      chk_pair($sformatf("midrst_pair_edge%0d", j), out, out_n);
    end

    // Toggle stress: 3 / 0 alternating each cycle
    for (int k = 0; k < 50; k++) begin
      if (k >= 3) begin
        chk($sformatf("toggle_cyc%0d", k), out,
            lsys_f(hist[k-3][0], hist[k-3][1], hist[k-3][2], hist[k-3][3]));
      end
      chk_pair($sformatf("toggle_pair_cyc%0d", k), out, out_n);
      hist[k] = (k % 2 == 0) ? 4'd3 : 4'd0;
      set_in(hist[k]);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/logic_system.md
# logic_system

Registered two-term AND-OR logic cell with complementary outputs. It computes `out = (a & b) | (c & d)` and `out_n = ~out` from four single-bit inputs. The inputs are typically board switches or other asynchronous sources, so each one passes through an optional synchronizer before the logic. The block sits at the edge of the design, between raw I/O and downstream synchronous logic.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops per input synchronizer. Legal values 0–3; 0 means the input is used directly.
- `REG_OUT`, default 1: 1 registers `out`/`out_n`; 0 makes them combinational from the synchronized inputs.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `a`, input, 1: first operand of product term P0.
- `b`, input, 1: second operand of product term P0.
- `c`, input, 1: first operand of product term P1.
- `d`, input, 1: second operand of product term P1.
- `out`, output, 1: `P0 | P1`.
- `out_n`, output, 1: bitwise complement of `out`.

## Operation
- Synchronized inputs are `as`, `bs`, `cs`, `ds`.
- Terms: `P0 = as & bs`, `P1 = cs & ds`, `f = P0 | P1`.
- `out = f` and `out_n = ~f`. Both come from the same register or net, so they are never equal in any cycle.
- Truth table index is `{d,c,b,a}` = 0..15. `out` = 1 exactly for indices 3, 7, 11, 12, 13, 14, 15; `out` = 0 otherwise.
- Synchronizer:
  - Each input has an independent `SYNC_STAGES`-deep shift chain.
  - There is no debounce and no cross-bit coherence guarantee.
- Reset (`rst_n` = 0):
  - All synchronizer flops clear to 0 immediately, without waiting for a clock edge.
  - The output register clears so `out` = 0 and `out_n` = 1.
  - With the synchronizer flops cleared, the logic sees `f` = 0, so outputs read `out` = 0, `out_n` = 1 during reset in every configuration except `SYNC_STAGES` = 0 with `REG_OUT` = 0.
- `SYNC_STAGES` = 0 with `REG_OUT` = 0: the block is purely combinational, `rst_n` and `clk` are unused, and outputs follow the inputs after propagation delay only.

## Timing
- Input-to-output latency is `SYNC_STAGES + REG_OUT` rising edges of `clk`. With defaults this is 3 cycles.
- An input change that meets setup before edge k shows on `out` after edge `k + SYNC_STAGES + REG_OUT - 1`.
- Reset assertion is asynchronous: outputs go to `out` = 0, `out_n` = 1 within the same cycle.
- Reset release takes effect at the first rising edge where `rst_n` = 1. The first valid output appears `SYNC_STAGES + REG_OUT` edges after release.
- Reset asserted mid-operation discards all in-flight samples. No partially propagated value may appear after release.
- Simultaneous changes on several inputs are each delayed by the same number of stages, so `f` is evaluated on one consistent sample set when all inputs were stable for that many cycles.
- Inputs toggling every cycle still produce exactly one output update per cycle. There is no output holdoff.

## Structure
- Package `logic_system_pkg` holds:
  - `SYNC_MAX` = 3;
  - the reset output constants `OUT_RST` = 1'b0 and `OUT_N_RST` = 1'b1;
  - function `lsys_f(a,b,c,d)` returning `(a&b)|(c&d)`, shared with the bench model.
- One sub-module, `sync_bit`, with parameter `STAGES`: an asynchronously reset flop chain of depth `STAGES`, or a wire when `STAGES` = 0. It is instantiated four times.
- Elaboration check: `SYNC_STAGES` must be within 0..3 and `REG_OUT` must be within 0..1. Other values fail elaboration.

## Test plan
- Exhaustive sweep, defaults: drive `{d,c,b,a}` = 0..15 and hold each value 10 cycles. After 3 cycles, `out` = 1 only at indices 3, 7, 11, 12–15, and `out_n` = `~out` in every cycle.
- Reset: apply inputs 4'hF, then assert `rst_n` = 0 between edges. `out` = 0 and `out_n` = 1 immediately, before the next edge. After release, `out` = 1 on the 3rd edge.
- Latency per configuration: run all 8 combinations of `SYNC_STAGES` ∈ {0..3} × `REG_OUT` ∈ {0,1}, stepping from input 0 to input 3. `out` must rise exactly `SYNC_STAGES + REG_OUT` edges later; with 0/0 the rise is combinational.
- Mid-flight reset: step the input from 0 to 12, then pulse `rst_n` low 1 edge later. `out` stays 0 and shows no stale 1. After release, `out` = 1 after 3 edges.
- Toggle stress: alternate inputs 3 and 0 every cycle for 50 cycles. `out` toggles every cycle with 3-cycle delay, and `out == out_n` never occurs.
- Boundary terms: check indices 1, 2, 4, 8, 5, 10 (each term partially active) give `out` = 0. Check 3 (P0 alone) and 12 (P1 alone) give `out` = 1.
